// File: rtl/mod_counter_pkg.sv
// Shared constants and the action type used by mod_counter's priority decode.
package mod_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int           WRAPS_W   = 8;
    localparam logic [7:0]   WRAPS_MAX = 8'd255;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_CLEAR,
        ACT_LOAD,
        ACT_STEP
    } act_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses up to WRAPS_MAX and holds there.
module sat_counter
    import mod_counter_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               inc,
    output logic [WRAPS_W-1:0] cnt
);

    logic [WRAPS_W-1:0] cnt_q;
    logic [WRAPS_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != WRAPS_MAX)) begin
            cnt_d = cnt_q + WRAPS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with clear, clamped load, terminal-count pulse and wrap counter.
// Define MOD_COUNTER_SAT_EN to hold at the bounds instead of wrapping.
module mod_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               up,
    input  logic               load,
    input  logic [WIDTH-1:0]   load_val,
    input  logic               clear,
    output logic [WIDTH-1:0]   q,
    output logic               tc,
    output logic [WRAPS_W-1:0] wraps
);

    if ((MODULUS < 2) || (MODULUS > (1 << WIDTH))) begin : g_bad_modulus
        $error("mod_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if ((RESET_VAL < 0) || (RESET_VAL >= MODULUS)) begin : g_bad_reset_val
        $error("mod_counter: RESET_VAL must be below MODULUS");
    end

    localparam logic [WIDTH-1:0] TOP   = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    act_e             act;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic             tc_q;
    logic             tc_d;

    always_comb begin
        act = ACT_HOLD;
        if (clear) begin
            act = ACT_CLEAR;
        end else if (load) begin
            act = ACT_LOAD;
        end else if (en) begin
            act = ACT_STEP;
        end
    end

    // tc_d flags a step that hits a bound; it doubles as the wrap-counter increment.
    always_comb begin
        q_d  = q_q;
        tc_d = 1'b0;
        case (act)
            ACT_CLEAR: q_d = '0;
            ACT_LOAD:  q_d = (load_val <= TOP) ? load_val : TOP;
            ACT_STEP: begin
                if (up == DIR_UP) begin
                    if (q_q == TOP) begin
                        tc_d = 1'b1;
`ifdef MOD_COUNTER_SAT_EN
                        q_d  = q_q;
`else
                        q_d  = '0;
`endif
                    end else begin
                        q_d = q_q + WIDTH'(1);
                    end
                end else begin
                    if (q_q == '0) begin
                        tc_d = 1'b1;
`ifdef MOD_COUNTER_SAT_EN
                        q_d  = q_q;
`else
                        q_d  = TOP;
`endif
                    end else begin
                        q_d = q_q - WIDTH'(1);
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q  <= RST_Q;
            tc_q <= 1'b0;
        end else begin
            q_q  <= q_d;
            tc_q <= tc_d;
        end
    end

    sat_counter u_wraps (
        .clk   (clk),
        .rst_n (reset),
        .clr   (act == ACT_CLEAR),
        .inc   (tc_d),
        .cnt   (wraps)
    );

    assign q  = q_q;
    assign tc = tc_q;

endmodule

// File: tb/tb_mod_counter.sv
// Self-checking bench for mod_counter (WIDTH=4, MODULUS=10) against an arithmetic reference model.
module tb_mod_counter;

    localparam int W   = 4;
    localparam int MOD = 10;

    logic         clk;
    logic         reset;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_val;
    logic         clear;
    logic [W-1:0] q;
    logic         tc;
    logic [7:0]   wraps;

    int n_tests = 0;
    int n_fail  = 0;

    int m_q     = 0;
    int m_tc    = 0;
    int m_wraps = 0;

    mod_counter #(.WIDTH(W), .MODULUS(MOD), .RESET_VAL(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .clear    (clear),
        .q        (q),
        .tc       (tc),
        .wraps    (wraps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "timeout");
    end

    // Reference: count as an integer, detect leaving 0..MOD-1, then wrap with modulo or hold.
    function automatic void model_edge(input logic c, input logic l, input int lv,
                                       input logic e, input logic u);
        int nq;
        if (!reset) begin
            m_q = 0; m_tc = 0; m_wraps = 0;
            return;
        end
        m_tc = 0;
        if (c) begin
            m_q = 0; m_wraps = 0;
        end else if (l) begin
            m_q = (lv < MOD) ? lv : MOD - 1;
        end else if (e) begin
            nq = u ? m_q + 1 : m_q - 1;
            if (nq < 0 || nq >= MOD) begin
                m_tc = 1;
                if (m_wraps < 255) m_wraps++;
`ifdef MOD_COUNTER_SAT_EN
                nq = m_q;
`else
                nq = (nq + MOD) % MOD;
`endif
            end
            m_q = nq;
        end
    endfunction

    task automatic check(input string tag);
        n_tests++;
        assert (q === W'(m_q)) else begin
            n_fail++;
            $error("FAIL %s q: got %0d expected %0d", tag, q, m_q);
        end
        n_tests++;
        assert (tc === 1'(m_tc)) else begin
            n_fail++;
            $error("FAIL %s tc: got %0d expected %0d", tag, tc, m_tc);
        end
        n_tests++;
        assert (wraps === 8'(m_wraps)) else begin
            n_fail++;
            $error("FAIL %s wraps: got %0d expected %0d", tag, wraps, m_wraps);
        end
    endtask

    task automatic cycle(input logic c, input logic l, input logic [W-1:0] lv,
                         input logic e, input logic u, input string tag, input bit quiet = 0);
        clear = c; load = l; load_val = lv; en = e; up = u;
        @(posedge clk);
        model_edge(c, l, int'(lv), e, u);
        #1;
        check(tag);
        if (!quiet)
            $display("[TB] %s rst=%0b clr=%0b ld=%0b lv=%0d en=%0b up=%0b -> q=%0d tc=%0b wraps=%0d",
                     tag, reset, c, l, lv, e, u, q, tc, wraps);
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0; clear = 1'b0;

        // 1: reset then count up through two wraps
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, "reset_hold");
        reset = 1'b1;
        for (int i = 0; i < 25; i++) cycle(0, 0, 0, 1, 1, "s1_up");

        // 2: from reset, count down
        reset = 1'b0;
        cycle(0, 0, 0, 0, 0, "s2_reset");
        reset = 1'b1;
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 1, 0, "s2_down");

        // 3: load wins over en, then clamp
        cycle(0, 1, 4'd7, 1, 1, "s3_load7");
        cycle(0, 0, 0, 1, 1, "s3_up");
        cycle(0, 1, 4'd12, 0, 1, "s3_load12");
        cycle(0, 1, 4'd15, 1, 0, "s3_load15");
        cycle(0, 1, 4'd0, 0, 1, "s3_load0");

        // 4: three wraps, clear beats load, then saturate wraps
        cycle(1, 0, 0, 0, 1, "s4_clear");
        for (int i = 0; i < 3 * MOD; i++) cycle(0, 0, 0, 1, 1, "s4_wrap3", 1);
        cycle(1, 1, 4'd5, 1, 1, "s4_clr_ld");
        for (int i = 0; i < 300 * MOD; i++) cycle(0, 0, 0, 1, 1, "s4_sat", 1);
        cycle(0, 0, 0, 1, 1, "s4_sat_end");

        // 5: async reset mid-cycle
        cycle(0, 1, 4'd5, 0, 1, "s5_load5");
        cycle(0, 0, 0, 1, 1, "s5_up6");
        #2;
        reset = 1'b0;
        model_edge(0, 0, 0, 0, 0);
        #1;
        check("s5_async");
        $display("[TB] s5_async reset low mid-cycle -> q=%0d tc=%0b wraps=%0d", q, tc, wraps);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1, "s5_resume");

        // randomized mix, including direction toggling and bound hits
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 19) == 0), ($urandom_range(0, 7) == 0),
                  W'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
